// File: rtl/opr_pkg.sv
// Shared widths, register/CSR index constants and the control bundle carried
// from the decoder through the operand-read stage to execute.
package opr_pkg;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NCSR  = 4;
    localparam int REG_W = $clog2(NREG);
    localparam int CSR_W = $clog2(NCSR);

    localparam logic [CSR_W-1:0] CSR_MCAUSE  = 2'd0;
    localparam logic [CSR_W-1:0] CSR_MEPC    = 2'd1;
    localparam logic [CSR_W-1:0] CSR_MSTATUS = 2'd2;
    localparam logic [CSR_W-1:0] CSR_MTVEC   = 2'd3;
    localparam logic [REG_W-1:0] REG_A7      = 5'd17;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_write_en;
        logic [CSR_W-1:0] csr_rd;
        logic             csreg_write_en;
        logic             ecall;
    } issue_ctrl_t;
endpackage

// File: rtl/opr_scoreboard.sv
// Busy bits for destinations issued but not yet retired, plus the RAW/WAW
// hazard query for the instruction currently offered by the decoder.
module opr_scoreboard
    import opr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write_en,
    input  logic [CSR_W-1:0] wb_csr_rd,
    input  logic             wb_csreg_write_en,
    input  logic             wb_ecall,
    input  logic             accept,
    input  issue_ctrl_t      ctrl,
    input  logic [REG_W-1:0] rs1,
    input  logic             rs1_en,
    input  logic [REG_W-1:0] rs2,
    input  logic             rs2_en,
    input  logic [CSR_W-1:0] csr_rs,
    input  logic             csr_rs_en,
    output logic             hazard
);
    logic [NREG-1:0] gpr_busy, gpr_clr, gpr_set, gpr_live;
    logic [NCSR-1:0] csr_busy, csr_clr, csr_set, csr_live;

    always_comb begin
        gpr_clr = '0;
        csr_clr = '0;
        gpr_set = '0;
        csr_set = '0;
        if (wb_valid) begin
            if (wb_reg_write_en && wb_rd != '0) gpr_clr[wb_rd] = 1'b1;
            if (wb_csreg_write_en)              csr_clr[wb_csr_rd] = 1'b1;
            if (wb_ecall)                       csr_clr[CSR_MCAUSE] = 1'b1;
        end
        if (accept) begin
            if (ctrl.reg_write_en && ctrl.rd != '0) gpr_set[ctrl.rd] = 1'b1;
            if (ctrl.csreg_write_en)                csr_set[ctrl.csr_rd] = 1'b1;
            if (ctrl.ecall)                         csr_set[CSR_MCAUSE] = 1'b1;
        end
    end

    // A bit retiring this cycle no longer blocks: its data is forwarded instead.
    assign gpr_live = {gpr_busy[NREG-1:1] & ~gpr_clr[NREG-1:1], 1'b0};
    assign csr_live = csr_busy & ~csr_clr;

    assign hazard = (rs1_en              && gpr_live[rs1])
                 || (rs2_en              && gpr_live[rs2])
                 || (ctrl.ecall          && gpr_live[REG_A7])
                 || (csr_rs_en           && csr_live[csr_rs])
                 || (ctrl.reg_write_en   && gpr_live[ctrl.rd])
                 || (ctrl.csreg_write_en && csr_live[ctrl.csr_rd])
                 || (ctrl.ecall          && csr_live[CSR_MCAUSE]);

    // Set is OR-ed after the clear so a same-cycle re-issue keeps the bit busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpr_busy <= '0;
            csr_busy <= '0;
        end else begin
            gpr_busy <= (gpr_busy & ~gpr_clr) | gpr_set;
            csr_busy <= (csr_busy & ~csr_clr) | csr_set;
        end
    end
endmodule

// File: rtl/opr_issue.sv
// Operand-read/issue stage: reads GPR/CSR operands with writeback forwarding,
// stalls on scoreboard hazards and registers the result towards execute.
module opr_issue
    import opr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic             in_rs1_en,
    input  logic             in_rs2_en,
    input  logic [CSR_W-1:0] in_csr_rs,
    input  logic             in_csr_rs_en,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_reg_write_en,
    input  logic [CSR_W-1:0] in_csr_rd,
    input  logic             in_csreg_write_en,
    input  logic             in_ecall,
    output logic [REG_W-1:0] rf_rs1,
    output logic [REG_W-1:0] rf_rs2,
    output logic [CSR_W-1:0] rf_csr_rs,
    input  logic [XLEN-1:0]  rsa,
    input  logic [XLEN-1:0]  rsb,
    input  logic [XLEN-1:0]  csra,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write_en,
    input  logic [XLEN-1:0]  wb_wd,
    input  logic [CSR_W-1:0] wb_csr_rd,
    input  logic             wb_csreg_write_en,
    input  logic [XLEN-1:0]  wb_csr_wd,
    input  logic             wb_ecall,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_src1,
    output logic [XLEN-1:0]  out_src2,
    output logic [XLEN-1:0]  out_csr,
    output logic [REG_W-1:0] out_rd,
    output logic             out_reg_write_en,
    output logic [CSR_W-1:0] out_csr_rd,
    output logic             out_csreg_write_en,
    output logic             out_ecall
);
    issue_ctrl_t     in_ctrl, out_ctrl;
    logic            hazard, accept;
    logic            wb_gpr_wr, wb_csr_hit;
    logic [XLEN-1:0] src1_n, src2_n, csr_n;

    assign rf_rs1    = in_rs1;
    assign rf_rs2    = in_rs2;
    assign rf_csr_rs = in_csr_rs;

    assign in_ctrl = '{rd: in_rd, reg_write_en: in_reg_write_en, csr_rd: in_csr_rd,
                       csreg_write_en: in_csreg_write_en, ecall: in_ecall};

    // Handshake: a transfer happens on any edge where valid && ready; valid never
    // depends on ready, and the producer holds its payload until the transfer.
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    opr_scoreboard u_sb (
        .clk               (clk),
        .rst               (rst),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_reg_write_en   (wb_reg_write_en),
        .wb_csr_rd         (wb_csr_rd),
        .wb_csreg_write_en (wb_csreg_write_en),
        .wb_ecall          (wb_ecall),
        .accept            (accept),
        .ctrl              (in_ctrl),
        .rs1               (in_rs1),
        .rs1_en            (in_rs1_en),
        .rs2               (in_rs2),
        .rs2_en            (in_rs2_en),
        .csr_rs            (in_csr_rs),
        .csr_rs_en         (in_csr_rs_en),
        .hazard            (hazard)
    );

    // The register file has not yet seen this cycle's retirement, so bypass it.
    assign wb_gpr_wr  = wb_valid && wb_reg_write_en;
    assign wb_csr_hit = wb_valid && ((wb_csreg_write_en && wb_csr_rd == in_csr_rs)
                                  || (wb_ecall && in_csr_rs == CSR_MCAUSE));

    assign src1_n = (in_rs1 == '0) ? '0 : (wb_gpr_wr && wb_rd == in_rs1) ? wb_wd : rsa;
    assign src2_n = (in_rs2 == '0) ? '0 : (wb_gpr_wr && wb_rd == in_rs2) ? wb_wd : rsb;
    assign csr_n  = wb_csr_hit ? wb_csr_wd : csra;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_csr   <= '0;
            out_ctrl  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_src1  <= src1_n;
            out_src2  <= src2_n;
            out_csr   <= csr_n;
            out_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_rd             = out_ctrl.rd;
    assign out_reg_write_en   = out_ctrl.reg_write_en;
    assign out_csr_rd         = out_ctrl.csr_rd;
    assign out_csreg_write_en = out_ctrl.csreg_write_en;
    assign out_ecall          = out_ctrl.ecall;
endmodule

// File: doc/opr_issue.md
Name: opr_issue

Overview:
- Operand-read/issue stage. Sits between the decoder and the execute unit, upstream of the writeback register file.
- Reads the GPR and CSR ports of the writeback unit and keeps a busy scoreboard of destinations that are issued but not yet written back.
- Stalls on RAW/WAW hazards and forwards same-cycle writeback data.
- Presents registered operands to the execute unit on a valid/ready handshake.

Parameters:
XLEN, 32, data width
NREG, 32, GPR count (x0 hardwired zero)
NCSR, 4, CSR count (0 mcause, 1 mepc, 2 mstatus, 3 mtvec)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction valid
in_ready  output  1  stage can accept
in_rs1/in_rs2  input  5 each  source GPR indices
in_rs1_en/in_rs2_en  input  1 each  source used
in_csr_rs  input  2  source CSR; in_csr_rs_en  input  1
in_rd  input  5; in_reg_write_en  input  1
in_csr_rd  input  2; in_csreg_write_en  input  1
in_ecall  input  1  ecall (reads x17, writes mcause)
rf_rs1/rf_rs2  output  5 each  register-file read indices (= in_rs1/in_rs2, combinational)
rf_csr_rs  output  2  CSR read index
rsa/rsb/csra  input  XLEN each  register-file read data (combinational)
wb_valid  input  1  writeback retiring this cycle
wb_rd  input  5; wb_reg_write_en  input  1; wb_wd  input  XLEN
wb_csr_rd  input  2; wb_csreg_write_en  input  1; wb_csr_wd  input  XLEN; wb_ecall  input  1
out_valid  output  1; out_ready  input  1
out_src1/out_src2/out_csr  output  XLEN each  operands
out_rd  output  5; out_reg_write_en  output  1
out_csr_rd  output  2; out_csreg_write_en  output  1; out_ecall  output  1

Behaviour:
- Reset (rst=0, async):
  - out_valid=0; all out_* data/control fields 0.
  - gpr_busy[31:0]=0; csr_busy[3:0]=0.
- Writeback clear, when wb_valid=1 (a retirement):
  - gpr_busy[wb_rd] is cleared if wb_reg_write_en and wb_rd!=0.
  - csr_busy[wb_csr_rd] is cleared if wb_csreg_write_en.
  - csr_busy[0] is cleared if wb_ecall.
- Hazard, combinational; a source is blocked if it is busy and not cleared this cycle:
  - rs1 if in_rs1_en.
  - rs2 if in_rs2_en.
  - x17 if in_ecall.
  - csr_rs if in_csr_rs_en.
  - WAW: in_rd busy if in_reg_write_en and rd!=0; in_csr_rd busy if in_csreg_write_en; CSR 0 busy if in_ecall.
  - Index 0 is never busy.
- in_ready = (!out_valid | out_ready) & !hazard.
- Accept = in_valid & in_ready. On accept, the output register loads at the next edge:
  - src1 = forward(rs1), src2 = forward(rs2), csr = forward_csr(csr_rs).
  - forward: if the same-cycle wb writes that index, use wb_wd / wb_csr_wd, else rsa / rsb / csra.
  - Index x0 always yields 0.
  - Control fields pass through.
- Accept also sets busy for the destinations (gpr_busy[in_rd], csr_busy[in_csr_rd], csr_busy[0] for ecall).
  - If a wb clear and an accept set hit the same bit in the same cycle, set wins.
- Output register:
  - out_valid rises one cycle after accept.
  - It holds its value until out_valid & out_ready.
  - Back-to-back accepts give 1 instruction/cycle when there are no hazards.
  - When out_ready=1 and there is no new accept, out_valid falls.
  - Operands are stable while out_valid & !out_ready.
- in_valid with disabled sources and no destination never stalls except on output backpressure.
- Latency: 1 cycle from accept to out_valid.
- A stall from a busy source resolves in the wb_valid cycle for that register (forwarded), not one cycle later.
- Reset mid-operation: all in-flight state is dropped; the scoreboard clears; out_valid=0 asynchronously.

Decomposition:
- Package opr_pkg holds XLEN, NREG, NCSR, the CSR index constants (CSR_MCAUSE=0, CSR_MEPC=1, CSR_MSTATUS=2, CSR_MTVEC=3), REG_A7=17, and a packed struct issue_ctrl_t (rd, reg_write_en, csr_rd, csreg_write_en, ecall).
- One sub-module, opr_scoreboard: holds the busy bits, set/clear logic and hazard query outputs.
- Forwarding and the output register stay in opr_issue.

Test Plan:
- Reset: rst=0 mid-stream -> out_valid=0, all busy bits 0, in_ready=1 after release with out_ready=1.
- RAW stall: issue rd=5 (addi), then rs1=5 -> in_ready=0 until wb_valid with wb_rd=5 and wb_wd=0x1234. In that same cycle in_ready=1, and next cycle out_src1=0x1234 (forwarded, rsa ignored).
- x0: issue rd=0, then rs1=0 -> no stall; out_src1=0 even if rsa=0xdeadbeef.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and out_* stable for 5 cycles. Release -> next instruction appears the following cycle.
- Ecall: pending write to x17, then ecall -> stalls until wb x17. Then csr_busy[0]=1, and a csrr of mcause (csr_rs=0) stalls until wb_ecall.
- Set-wins collision: wb clears x7 while a new instruction with rd=7 is accepted the same cycle -> gpr_busy[7]=1 afterwards; a following rs1=7 stalls.
